// File: rtl/memory_sram_pkg.sv
// Shared types and geometry for one 256 x 32 data-memory bank.
// Optional write-through of the merged word onto Q: MEMORY_SRAM_WRITE_THROUGH_EN.
package memory_sram_pkg;

  localparam int ADDR_W  = 12;
  localparam int DATA_W  = 32;
  localparam int DEPTH   = 256;
  localparam int IDX_W   = 8;
  localparam int IDX_LSB = 2;

  typedef logic [DATA_W-1:0] word_t;
  typedef logic [IDX_W-1:0]  idx_t;

  typedef enum logic [1:0] {
    OP_IDLE  = 2'd0,
    OP_READ  = 2'd1,
    OP_WRITE = 2'd2
  } op_e;

  // CEN is active-high and WEN is active-low; fold both into one operation code.
  function automatic op_e decode_op(input logic cen, input logic wen);
    if (!cen) begin
      return OP_IDLE;
    end
    return wen ? OP_READ : OP_WRITE;
  endfunction

endpackage

// File: rtl/memory_sram_merge.sv
// Bit-granular write merge: keeps old bits where the mask is 0, takes new data where it is 1.
module memory_sram_merge
  import memory_sram_pkg::*;
(
  input  logic [DATA_W-1:0] old_word,
  input  logic [DATA_W-1:0] wdata,
  input  logic [DATA_W-1:0] bwen,
  output logic [DATA_W-1:0] merged
);

  assign merged = (old_word & ~bwen) | (wdata & bwen);

endmodule

// File: rtl/memory_sram.sv
// One 1 KiB data-memory bank: 256 x 32-bit flop array, bit write mask, registered read port.
// Define MEMORY_SRAM_WRITE_THROUGH_EN to also load Q with the merged word on write cycles.
module memory_sram
  import memory_sram_pkg::*;
(
  input  logic              CLK,
  input  logic              RSTn,
  input  logic              CEN,
  input  logic              WEN,
  input  logic [DATA_W-1:0] BWEN,
  input  logic [ADDR_W-1:0] A,
  input  logic [DATA_W-1:0] D,
  output logic [DATA_W-1:0] Q
);

  op_e   op;
  idx_t  idx;
  word_t rd_word;
  word_t merged;
  word_t q_d;
  word_t q_q;
  word_t mem_d [DEPTH];
  word_t mem_q [DEPTH];

  // Bank-select and byte-offset bits are decoded by the load/store unit, so they alias here.
  logic unused_a;
  assign unused_a = ^{A[ADDR_W-1:IDX_LSB+IDX_W], A[IDX_LSB-1:0]};

  assign op      = decode_op(CEN, WEN);
  assign idx     = A[IDX_LSB +: IDX_W];
  assign rd_word = mem_q[idx];

  memory_sram_merge u_merge (
    .old_word (rd_word),
    .wdata    (D),
    .bwen     (BWEN),
    .merged   (merged)
  );

  always_comb begin
    mem_d = mem_q;
    if (op == OP_WRITE) begin
      mem_d[idx] = merged;
    end
  end

  always_comb begin
    q_d = q_q;
    case (op)
      OP_READ: q_d = rd_word;
`ifdef MEMORY_SRAM_WRITE_THROUGH_EN
      OP_WRITE: q_d = merged;
`endif
      default: q_d = q_q;
    endcase
  end

  // Clearing the whole array keeps every read defined and discards any write in flight.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      q_q <= '0;
    end else begin
      mem_q <= mem_d;
      q_q   <= q_d;
    end
  end

  assign Q = q_q;

endmodule

// File: tb/tb_memory_sram.sv
// Self-checking bench for memory_sram: table-driven vectors with an expected-Q scoreboard queue.
module tb_memory_sram;

`ifdef MEMORY_SRAM_WRITE_THROUGH_EN
  localparam bit WT = 1'b1;
`else
  localparam bit WT = 1'b0;
`endif

  typedef struct {
    logic        cen;
    logic        wen;
    logic [31:0] bwen;
    logic [11:0] a;
    logic [31:0] d;
    logic [31:0] exp_q;
    logic [31:0] exp_q_wt;
  } vec_t;

  localparam int NVEC = 20;

  logic        CLK;
  logic        RSTn;
  logic        CEN;
  logic        WEN;
  logic [31:0] BWEN;
  logic [11:0] A;
  logic [31:0] D;
  logic [31:0] Q;

  logic [31:0] exp_queue [$];
  vec_t        vecs [NVEC];
  int          checks;
  int          failures;

  memory_sram dut (
    .CLK  (CLK),
    .RSTn (RSTn),
    .CEN  (CEN),
    .WEN  (WEN),
    .BWEN (BWEN),
    .A    (A),
    .D    (D),
    .Q    (Q)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout required finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Pops the oldest prediction and compares it with Q as seen right now.
  task automatic checkOutput(input string tag);
    logic [31:0] expv;
    checks++;
    if (exp_queue.size() == 0) begin
      failures++;
      $display("[TB] FAIL %s: got %08h required <scoreboard entry>", tag, Q);
    end else begin
      expv = exp_queue.pop_front();
      if (Q !== expv) begin
        failures++;
        $display("[TB] FAIL %s: got %08h required %08h", tag, Q, expv);
      end
    end
  endtask

  // Drives one request on the falling edge, predicts Q, and samples just after the rising edge.
  task automatic applyStimulus(input vec_t v);
    @(negedge CLK);
    CEN  = v.cen;
    WEN  = v.wen;
    BWEN = v.bwen;
    A    = v.a;
    D    = v.d;
    exp_queue.push_back(WT ? v.exp_q_wt : v.exp_q);
    @(posedge CLK);
    #1;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    RSTn = 1'b0;
    CEN  = 1'b0;
    WEN  = 1'b1;
    BWEN = '0;
    A    = '0;
    D    = '0;

    //          cen   wen   bwen          a        d             exp_q         exp_q_wt
    vecs[0]  = '{1'b1, 1'b0, 32'hFFFFFFFF, 12'h004, 32'hDEADBEEF, 32'h00000000, 32'hDEADBEEF};
    vecs[1]  = '{1'b1, 1'b1, 32'h00000000, 12'h004, 32'h00000000, 32'hDEADBEEF, 32'hDEADBEEF};
    vecs[2]  = '{1'b1, 1'b0, 32'hFFFFFFFF, 12'h008, 32'h11223344, 32'hDEADBEEF, 32'h11223344};
    vecs[3]  = '{1'b1, 1'b0, 32'h0000FF00, 12'h008, 32'hAABBCCDD, 32'hDEADBEEF, 32'h1122CC44};
    vecs[4]  = '{1'b1, 1'b1, 32'hFFFFFFFF, 12'h008, 32'h00000000, 32'h1122CC44, 32'h1122CC44};
    vecs[5]  = '{1'b1, 1'b0, 32'hFFFF0000, 12'h008, 32'h55667788, 32'h1122CC44, 32'h5566CC44};
    vecs[6]  = '{1'b1, 1'b1, 32'h00000000, 12'h008, 32'h00000000, 32'h5566CC44, 32'h5566CC44};
    vecs[7]  = '{1'b0, 1'b0, 32'hFFFFFFFF, 12'h004, 32'hFFFFFFFF, 32'h5566CC44, 32'h5566CC44};
    vecs[8]  = '{1'b1, 1'b1, 32'h00000000, 12'h004, 32'h00000000, 32'hDEADBEEF, 32'hDEADBEEF};
    vecs[9]  = '{1'b1, 1'b0, 32'h00000000, 12'h004, 32'hFFFFFFFF, 32'hDEADBEEF, 32'hDEADBEEF};
    vecs[10] = '{1'b1, 1'b1, 32'h00000000, 12'h004, 32'h00000000, 32'hDEADBEEF, 32'hDEADBEEF};
    vecs[11] = '{1'b1, 1'b0, 32'hFFFFFFFF, 12'h3FC, 32'hCAFEF00D, 32'hDEADBEEF, 32'hCAFEF00D};
    vecs[12] = '{1'b1, 1'b1, 32'h00000000, 12'hFFF, 32'h00000000, 32'hCAFEF00D, 32'hCAFEF00D};
    vecs[13] = '{1'b1, 1'b1, 32'h00000000, 12'h000, 32'h00000000, 32'h00000000, 32'h00000000};
    vecs[14] = '{1'b1, 1'b1, 32'h00000000, 12'hBFE, 32'h00000000, 32'hCAFEF00D, 32'hCAFEF00D};
    vecs[15] = '{1'b1, 1'b0, 32'hFFFFFFFF, 12'h010, 32'h12345678, 32'hCAFEF00D, 32'h12345678};
    vecs[16] = '{1'b1, 1'b1, 32'h00000000, 12'h010, 32'h00000000, 32'h12345678, 32'h12345678};
    vecs[17] = '{1'b1, 1'b0, 32'h000000FF, 12'h413, 32'hFFFFFFAB, 32'h12345678, 32'h123456AB};
    vecs[18] = '{1'b1, 1'b1, 32'h00000000, 12'h010, 32'h00000000, 32'h123456AB, 32'h123456AB};
    vecs[19] = '{1'b0, 1'b1, 32'h00000000, 12'h004, 32'h00000000, 32'h123456AB, 32'h123456AB};

    #3;
    exp_queue.push_back(32'h0);
    checkOutput("reset_q");
    @(negedge CLK);
    @(negedge CLK);
    RSTn = 1'b1;

    for (int i = 0; i < NVEC; i++) begin
      applyStimulus(vecs[i]);
      checkOutput($sformatf("vec%0d", i));
    end

    // Reset asserted mid-cycle while a full write to word 1 is being presented.
    @(negedge CLK);
    CEN  = 1'b1;
    WEN  = 1'b0;
    BWEN = 32'hFFFFFFFF;
    A    = 12'h004;
    D    = 32'hFFFFFFFF;
    #2;
    RSTn = 1'b0;
    #1;
    exp_queue.push_back(32'h0);
    checkOutput("reset_async_q");
    @(posedge CLK);
    #1;
    exp_queue.push_back(32'h0);
    checkOutput("reset_hold_q");
    @(negedge CLK);
    CEN  = 1'b0;
    RSTn = 1'b1;

    applyStimulus('{1'b1, 1'b1, 32'h0, 12'h000, 32'h0, 32'h0, 32'h0});
    checkOutput("post_reset_idx0");
    applyStimulus('{1'b1, 1'b1, 32'h0, 12'h014, 32'h0, 32'h0, 32'h0});
    checkOutput("post_reset_idx5");
    applyStimulus('{1'b1, 1'b1, 32'h0, 12'h3FC, 32'h0, 32'h0, 32'h0});
    checkOutput("post_reset_idx255");
    applyStimulus('{1'b1, 1'b1, 32'h0, 12'h004, 32'h0, 32'h0, 32'h0});
    checkOutput("post_reset_idx1");
    applyStimulus('{1'b1, 1'b1, 32'h0, 12'h008, 32'h0, 32'h0, 32'h0});
    checkOutput("post_reset_idx2");

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
